load_store_unit: RTL and testbench

- Sits between the ALU/register-file outputs of the single-cycle core and an external data memory or bus that takes several cycles to respond.
- Replaces the ideal one-cycle data memory with a req/ack handshake.
- Handles RISC-V byte, halfword and word loads and stores: byte lanes, byte enables, sign/zero extension and alignment checks.
- Asserts stall to freeze the PC and register writeback until the access completes.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 84 ++++++++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store unit
//
// Purpose: funct3 access codes, controller state encoding and the timer
// width helper used by load_store_unit and lsu_lane_align.
// Ports: none (package).
package lsu_pkg;

  // funct3 encodings (instruction[14:12]) for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_e;

  // Timer must be able to hold values up to TIMEOUT_CYCLES
  function automatic int timer_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering, extension and validity check
//
// Purpose: purely combinational helper. The request side works on the
// live core inputs (validity, byte enables, replicated store data); the
// load side works on the access fields captured when the bus request began.
// Ports:
//   funct3_i, addr_lo_i      request size/sign and address bits [1:0]
//   read_i, write_i          request type from the control unit
//   store_data_i             rs2 value
//   valid_o                  request is legal and aligned
//   be_o, wdata_o            byte enables and lane-replicated store data
//   ld_funct3_i, ld_addr_lo_i  captured size/sign and lane of the load
//   rdata_i                  read word from the bus
//   load_ext_o               extracted and extended load value
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] store_data_i,
  output logic        valid_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_ext_o
);

  logic       f3_legal;
  logic       aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    f3_legal = 1'b0;
    if (read_i) begin
      f3_legal = (funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W) ||
                 (funct3_i == F3_BU) || (funct3_i == F3_HU);
    end else if (write_i) begin
      f3_legal = (funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W);
    end

    // funct3[1:0] carries the access size for every legal code
    case (funct3_i[1:0])
      2'b01:   aligned = (addr_lo_i[0] == 1'b0);
      2'b10:   aligned = (addr_lo_i == 2'b00);
      default: aligned = 1'b1;
    endcase

    valid_o = f3_legal && aligned && !(read_i && write_i);

    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
      end
    endcase
  end

  assign byte_sel = rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{ld_addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    case (ld_funct3_i)
      F3_B:    load_ext_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext_o = {24'd0, byte_sel};
      F3_H:    load_ext_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_ext_o = {16'd0, half_sel};
      default: load_ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle req/ack load/store unit for the core
//
// Purpose: turns a single-cycle core's data-memory access into a bus
// transaction, stalling the core until the bus acknowledges or times out.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   mem_read_i, mem_write_i   load/store request from the control unit
//   funct3_i, addr_i          access size/sign and byte address
//   store_data_i              rs2 value
//   load_data_o               extended load result, valid in DONE
//   stall_o                   hold PC and writeback
//   fault_o                   one-cycle pulse: invalid, misaligned or timeout
//   bus_req_o .. bus_be_o     registered bus request fields
//   bus_ack_i, bus_rdata_i    bus completion and read word
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] load_data_q, load_data_d;

  logic        req_valid;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] load_ext;
  logic        request;
  logic        invalid_req;

  lsu_lane_align u_lane_align (
    .funct3_i     (funct3_i),
    .addr_lo_i    (addr_i[1:0]),
    .read_i       (mem_read_i),
    .write_i      (mem_write_i),
    .store_data_i (store_data_i),
    .valid_o      (req_valid),
    .be_o         (req_be),
    .wdata_o      (req_wdata),
    .ld_funct3_i  (funct3_q),
    .ld_addr_lo_i (addr_lo_q),
    .rdata_i      (bus_rdata_i),
    .load_ext_o   (load_ext)
  );

  assign request     = mem_read_i | mem_write_i;
  assign invalid_req = (state_q == IDLE) && request && !req_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      timeout_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    load_data_d = load_data_q;
    stall_o     = 1'b0;
    fault_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (request) begin
          if (req_valid) begin
            stall_o   = 1'b1;
            state_d   = ACCESS;
            timer_d   = '0;
            timeout_d = 1'b0;
            we_d      = mem_write_i;
            addr_d    = {addr_i[31:2], 2'b00};
            wdata_d   = req_wdata;
            be_d      = req_be;
            funct3_d  = funct3_i;
            addr_lo_d = addr_i[1:0];
          end else begin
            fault_o = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall_o = 1'b1;
        timer_d = timer_q + TW'(1);
        // ack is checked first so it wins over a coincident timeout
        if (bus_ack_i) begin
          state_d     = DONE;
          load_data_d = we_q ? 32'd0 : load_ext;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = DONE;
          timeout_d   = 1'b1;
          load_data_d = 32'd0;
        end
      end
      DONE: begin
        // the core advances on this edge, so no new access starts here
        fault_o = timeout_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_data_o = invalid_req ? 32'd0 : load_data_q;
  assign bus_req_o   = (state_q == ACCESS);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_be_o    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [31:0] load_data;
  logic        stall;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .store_data_i (store_data),
    .load_data_o  (load_data),
    .stall_o      (stall),
    .fault_o      (fault),
    .bus_req_o    (bus_req),
    .bus_we_o     (bus_we),
    .bus_addr_o   (bus_addr),
    .bus_wdata_o  (bus_wdata),
    .bus_be_o     (bus_be),
    .bus_ack_i    (bus_ack),
    .bus_rdata_i  (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model written from the access rules with plain arithmetic
  function automatic logic m_valid(input logic mr, input logic mw, input int f3, input int unsigned a);
    int sz;
    if (mr && mw) return 1'b0;
    if (!mr && !mw) return 1'b0;
    if (mr && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b0;
    if (mw && f3 > 2) return 1'b0;
    sz = f3 % 4;
    if (sz == 1 && (a % 2) != 0) return 1'b0;
    if (sz == 2 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_be(input int f3, input int unsigned a);
    case (f3 % 4)
      0:       return 4'(1 << (a % 4));
      1:       return ((a % 4) >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] sd);
    case (f3 % 4)
      0:       return (sd & 32'hFF) * 32'h0101_0101;
      1:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input int f3, input int unsigned a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4:       return b;
      1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5:       return h;
      default: return rd;
    endcase
  endfunction

  // waits < 0 means the bus never acknowledges
  task automatic run_access(input string nm, input logic mr, input logic mw,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd,
                            input int waits, input logic ev, input logic [3:0] ebe,
                            input logic [31:0] ewd, input logic [31:0] eld);
    int stalls;
    int acc;
    int exp_acc;
    @(negedge clk);
    mem_read = mr; mem_write = mw; funct3 = f3; addr = a; store_data = sd;
    #1;
    if (!ev) begin
      check({nm, " fault"}, {31'd0, fault}, 32'd1);
      check({nm, " stall"}, {31'd0, stall}, 32'd0);
      check({nm, " ld0"}, load_data, 32'd0);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      check({nm, " no_req"}, {31'd0, bus_req}, 32'd0);
      check({nm, " fault_pulse"}, {31'd0, fault}, 32'd0);
      return;
    end
    check({nm, " stall0"}, {31'd0, stall}, 32'd1);
    check({nm, " fault0"}, {31'd0, fault}, 32'd0);
    check({nm, " req0"}, {31'd0, bus_req}, 32'd0);
    stalls = 1;
    acc = 0;
    exp_acc = (waits < 0) ? TO : waits + 1;
    @(negedge clk);
    while (bus_req && acc < 40) begin
      acc++;
      stalls += int'(stall);
      check({nm, " addr"}, bus_addr, a & 32'hFFFF_FFFC);
      check({nm, " we"}, {31'd0, bus_we}, {31'd0, mw});
      check({nm, " be"}, {28'd0, bus_be}, {28'd0, ebe});
      if (mw) check({nm, " wdata"}, bus_wdata, ewd);
      bus_ack = (waits >= 0) && (acc == waits + 1);
      bus_rdata = bus_ack ? rd : $urandom;
      @(negedge clk);
    end
    bus_ack = 1'b0;
    check({nm, " acc_cycles"}, acc, exp_acc);
    check({nm, " stall_cycles"}, stalls, exp_acc + 1);
    check({nm, " done_stall"}, {31'd0, stall}, 32'd0);
    check({nm, " done_fault"}, {31'd0, fault}, (waits < 0) ? 32'd1 : 32'd0);
    check({nm, " load_data"}, load_data, (waits < 0) ? 32'd0 : eld);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    #1;
    check({nm, " idle_req"}, {31'd0, bus_req}, 32'd0);
    check({nm, " idle_fault"}, {31'd0, fault}, 32'd0);
  endtask

  typedef struct {
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          waits;
    logic        ev;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        2, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h13, 32'h0,        32'h80FF1234, 1, 1'b1, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h13, 32'h0,        32'h80FF1234, 0, 1'b1, 4'h8, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'h80FF1234, 1, 1'b1, 4'hC, 32'h0,        32'hFFFF80FF};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h12, 32'h0,        32'h80FF1234, 2, 1'b1, 4'hC, 32'h0,        32'h000080FF};
    vecs[5]  = '{1'b0, 1'b1, 3'b001, 32'h16, 32'h1234ABCD, 32'h0,        0, 1'b1, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h21, 32'h0,        32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'b011, 32'h20, 32'h0,        32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1'b1, 3'b010, 32'h20, 32'h0,        32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h11, 32'h000000A5, 32'h0,        3, 1'b1, 4'h2, 32'hA5A5A5A5, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h24, 32'h0,        32'hCAFEF00D, 0, 1'b1, 4'hF, 32'h0,        32'hCAFEF00D};
    vecs[11] = '{1'b0, 1'b1, 3'b101, 32'h14, 32'h12345678, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'b001, 32'h13, 32'h0,        32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h10, 32'h0,        32'h0000007F, 1, 1'b1, 4'h1, 32'h0,        32'h0000007F};

    // reset state
    #12;
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst fault", {31'd0, fault}, 32'd0);
    check("rst bus_req", {31'd0, bus_req}, 32'd0);
    check("rst load_data", load_data, 32'd0);
    check("rst bus_be", {28'd0, bus_be}, 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_access($sformatf("vec%0d", i), vecs[i].mr, vecs[i].mw, vecs[i].f3, vecs[i].a,
                 vecs[i].sd, vecs[i].rd, vecs[i].waits, vecs[i].ev, vecs[i].be,
                 vecs[i].wd, vecs[i].ld);
    end

    // ack with no access in flight is ignored
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h5555AAAA;
    @(negedge clk);
    check("stray_ack req", {31'd0, bus_req}, 32'd0);
    check("stray_ack stall", {31'd0, stall}, 32'd0);
    check("stray_ack fault", {31'd0, fault}, 32'd0);
    bus_ack = 1'b0;

    // timeout: no ack ever
    run_access("timeout", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, -1, 1'b1, 4'hF, 32'h0, 32'h0);

    // reset in the middle of an access
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h30;
    @(negedge clk);
    check("midrst pre_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1; mem_read = 1'b0;
    #1;
    check("midrst req", {31'd0, bus_req}, 32'd0);
    check("midrst stall", {31'd0, stall}, 32'd0);
    check("midrst be", {28'd0, bus_be}, 32'd0);
    check("midrst addr", bus_addr, 32'd0);
    check("midrst load_data", load_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_access("post_rst", 1'b1, 1'b0, 3'b001, 32'h32, 32'h0, 32'h80010000, 1, 1'b1, 4'hC, 32'h0, 32'hFFFF8001);

    // randomized accesses against the reference model
    for (int i = 0; i < 40; i++) begin
      logic        mr, mw, ev;
      logic [2:0]  f3;
      logic [31:0] a, sd, rd;
      int          sel, w;
      sel = $urandom_range(0, 9);
      mr = (sel == 0) || (sel < 5);
      mw = (sel == 0) || (sel >= 5);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      sd = $urandom;
      rd = $urandom;
      w  = $urandom_range(0, 3);
      ev = m_valid(mr, mw, int'(f3), a);
      run_access($sformatf("rnd%0d", i), mr, mw, f3, a, sd, rd, w, ev,
                 m_be(int'(f3), a), m_wdata(int'(f3), sd),
                 mw ? 32'd0 : m_load(int'(f3), a, rd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
